dff_rs_reg_n: RTL and testbench

//   WIDTH-bit successor of the single-bit set/reset D flip-flop.

---
 rtl/dff_rs_reg_n.sv | 110 +++++++++++
 tb/tb_dff_rs_reg_n.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dff_rs_reg_n.sv
// WIDTH-bit general-purpose state register with synchronous reset/set and an
// opcode-selected next-state function (load, shift/rotate, increment/decrement).
module dff_rs_reg_n #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] SET_VALUE   = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             co,
   output logic             zero
);

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_SHR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_INC  = 3'b110;
   localparam logic [2:0] OP_DEC  = 3'b111;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_next;
   logic             sout_next;
   logic             co_next;

   // Priority: reset > set > enabled op; en=0 leaves everything untouched so
   // op and d are never looked at while the register is idle.
   always_comb begin
      q_next    = q;
      sout_next = sout;
      co_next   = co;
      if (reset) begin
         q_next    = RESET_VALUE;
         sout_next = 1'b0;
         co_next   = 1'b0;
      end else if (set) begin
         q_next    = SET_VALUE;
         sout_next = 1'b0;
         co_next   = 1'b0;
      end else if (en) begin
         case (op)
            OP_HOLD: begin
               q_next    = q;
               sout_next = sout;
               co_next   = co;
            end
            OP_LOAD: begin
               q_next    = d;
               sout_next = 1'b0;
               co_next   = 1'b0;
            end
            OP_SHL: begin
               q_next    = {q[WIDTH-2:0], sin};
               sout_next = q[WIDTH-1];
               co_next   = 1'b0;
            end
            OP_SHR: begin
               q_next    = {sin, q[WIDTH-1:1]};
               sout_next = q[0];
               co_next   = 1'b0;
            end
            OP_ROL: begin
               q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
               sout_next = q[WIDTH-1];
               co_next   = 1'b0;
            end
            OP_ROR: begin
               q_next    = {q[0], q[WIDTH-1:1]};
               sout_next = q[0];
               co_next   = 1'b0;
            end
            OP_INC: begin
               q_next    = q + ONE;
               sout_next = 1'b0;
               co_next   = (q == '1);
            end
            OP_DEC: begin
               q_next    = q - ONE;
               sout_next = 1'b0;
               co_next   = (q == '0);
            end
            default: begin
               q_next    = q;
               sout_next = sout;
               co_next   = co;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      q    <= q_next;
      sout <= sout_next;
      co   <= co_next;
   end

   // Combinational so that zero tracks q on the same cycle.
   assign zero = (q == '0);

endmodule

// File: tb/tb_dff_rs_reg_n.sv
// Bench for dff_rs_reg_n: directed scenarios with literal expectations, then
// random traffic checked every cycle against an arithmetic reference model.
module tb_dff_rs_reg_n;

   logic       clk;
   logic       reset;
   logic       set;
   logic       en;
   logic [2:0] op;
   logic [7:0] d;
   logic       sin;
   logic [7:0] q;
   logic       sout;
   logic       co;
   logic       zero;

   int n_cmp;
   int n_err;

   // reference model state (unsigned integers, modulo 256)
   int mq;
   int ms;
   int mc;
   bit mvalid;

   dff_rs_reg_n #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .set   (set),
      .en    (en),
      .op    (op),
      .d     (d),
      .sin   (sin),
      .q     (q),
      .sout  (sout),
      .co    (co),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input bit r, input bit s, input bit e,
                               input int o, input int dd, input int si);
      if (r) begin
         mq = 0; ms = 0; mc = 0; mvalid = 1'b1;
      end else if (!mvalid) begin
         // nothing known before the first reset
      end else if (s) begin
         mq = 255; ms = 0; mc = 0;
      end else if (e) begin
         case (o)
            1: begin mq = dd; ms = 0; mc = 0; end
            2: begin ms = mq / 128; mq = (mq * 2 + si) % 256; mc = 0; end
            3: begin ms = mq % 2; mq = mq / 2 + si * 128; mc = 0; end
            4: begin ms = mq / 128; mq = (mq * 2) % 256 + mq / 128; mc = 0; end
            5: begin ms = mq % 2; mq = mq / 2 + (mq % 2) * 128; mc = 0; end
            6: begin mc = (mq == 255); mq = (mq + 1) % 256; ms = 0; end
            7: begin mc = (mq == 0); mq = (mq + 255) % 256; ms = 0; end
            default: ;
         endcase
      end
   endtask

   // One clock edge with the given inputs; model advances on the same edge.
   task automatic step(input logic r, input logic s, input logic e,
                       input logic [2:0] o, input logic [7:0] dd, input logic si);
      reset = r; set = s; en = e; op = o; d = dd; sin = si;
      @(posedge clk);
      model_update(r, s, e, int'(o), int'(dd), int'(si));
      #1;
   endtask

   // Compare process: every cycle once the model is defined.
   always @(negedge clk) begin
      if (mvalid) begin
         chk("cyc_q", int'(q), mq);
         chk("cyc_sout", int'(sout), ms);
         chk("cyc_co", int'(co), mc);
         chk("cyc_zero", int'(zero), int'(mq == 0));
      end
   end

   initial begin
      n_cmp = 0; n_err = 0;
      mq = 0; ms = 0; mc = 0; mvalid = 1'b0;
      reset = 1'b0; set = 1'b0; en = 1'b0; op = 3'd0; d = 8'h00; sin = 1'b0;
      @(posedge clk); #1;

      // 1: reset then set
      step(1, 0, 0, 3'd0, 8'h00, 0);
      chk("s1_q", int'(q), 8'h00); chk("s1_sout", int'(sout), 0);
      chk("s1_co", int'(co), 0);   chk("s1_zero", int'(zero), 1);
      step(0, 1, 0, 3'd0, 8'h00, 0);
      chk("s1_set_q", int'(q), 8'hFF); chk("s1_set_zero", int'(zero), 0);

      // 2: load then idle with op=INC and with X on op/d
      step(0, 0, 1, 3'd1, 8'hA5, 0);
      chk("s2_load", int'(q), 8'hA5); chk("s2_model", mq, 8'hA5);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 3'd6, 8'h00, 0);
      chk("s2_hold", int'(q), 8'hA5);
      step(0, 0, 0, 3'bxxx, 8'hxx, 0);
      chk("s2_hold_x", int'(q), 8'hA5);

      // 3: shift and rotate
      step(0, 0, 1, 3'd1, 8'h81, 0);
      step(0, 0, 1, 3'd2, 8'h00, 0);
      chk("s3_shl_q", int'(q), 8'h02); chk("s3_shl_sout", int'(sout), 1);
      step(0, 0, 1, 3'd5, 8'h00, 0);
      chk("s3_ror1_q", int'(q), 8'h01); chk("s3_ror1_sout", int'(sout), 0);
      step(0, 0, 1, 3'd5, 8'h00, 0);
      chk("s3_ror2_q", int'(q), 8'h80); chk("s3_ror2_sout", int'(sout), 1);
      chk("s3_model", mq, 8'h80);

      // 4: counter wrap both ways
      step(0, 0, 1, 3'd1, 8'hFE, 0);
      step(0, 0, 1, 3'd6, 8'h00, 0);
      chk("s4_inc1_q", int'(q), 8'hFF); chk("s4_inc1_co", int'(co), 0);
      step(0, 0, 1, 3'd6, 8'h00, 0);
      chk("s4_inc2_q", int'(q), 8'h00); chk("s4_inc2_co", int'(co), 1);
      chk("s4_inc2_zero", int'(zero), 1);
      step(0, 0, 1, 3'd7, 8'h00, 0);
      chk("s4_dec_q", int'(q), 8'hFF); chk("s4_dec_co", int'(co), 1);
      chk("s4_model_co", mc, 1);

      // 5: reset beats set beats op
      step(1, 1, 1, 3'd1, 8'h3C, 0);
      chk("s5_rs_q", int'(q), 8'h00);
      step(0, 1, 1, 3'd1, 8'h3C, 0);
      chk("s5_set_q", int'(q), 8'hFF);

      // 6: reset in the middle of an SHR stream
      step(1, 0, 0, 3'd0, 8'h00, 0);
      for (int i = 1; i <= 8; i++) begin
         step((i == 4), 0, 1, 3'd3, 8'h00, 1);
         if (i == 4) chk("s6_reset_q", int'(q), 8'h00);
      end
      chk("s6_end_q", int'(q), 8'hF0); chk("s6_model", mq, 8'hF0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

      @(negedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
